// File: rtl/uc_partida_if.sv
// Handshake and status bundle between the PoliLobinho game-flow control unit and its datapath.
// The slave side is the control unit; the master side is whatever drives it.
interface uc_partida_if #(
  parameter int N_JOGADORES = 8,
  parameter int MAX_RODADAS = 15
);
  localparam int WJ = $clog2(N_JOGADORES);
  localparam int WR = $clog2(MAX_RODADAS + 1);

  logic                   jogar;
  logic                   passa;
  logic [N_JOGADORES-1:0] vivos;
  logic                   fim_jogo;
  logic                   rst_global;
  logic                   zera_CS;
  logic                   e_seed_reg;
  logic                   e_acao_noite;
  logic                   e_voto;
  logic                   e_apura;
  logic                   timeout;
  logic                   noite;
  logic                   pronto;
  logic [WJ-1:0]          jogador_atual;
  logic [WR-1:0]          rodada;
  logic [4:0]             db_estado;

  modport slave (
    input  jogar, passa, vivos, fim_jogo,
    output rst_global, zera_CS, e_seed_reg, e_acao_noite, e_voto, e_apura,
           timeout, noite, pronto, jogador_atual, rodada, db_estado
  );

  modport master (
    output jogar, passa, vivos, fim_jogo,
    input  rst_global, zera_CS, e_seed_reg, e_acao_noite, e_voto, e_apura,
           timeout, noite, pronto, jogador_atual, rodada, db_estado
  );
endinterface

// File: rtl/uc_partida.sv
// PoliLobinho game-flow control unit: start sequence, night turns, day votes, tally
// and end-of-game check, walking every player slot once per phase with a turn timer.
module uc_partida #(
  parameter int N_JOGADORES = 8,
  parameter int TEMPO_TURNO = 500,
  parameter int MAX_RODADAS = 15
) (
  input  logic          clock,
  input  logic          reset,
  uc_partida_if.slave   bus
);
  localparam int WJ = $clog2(N_JOGADORES);
  localparam int WT = $clog2(TEMPO_TURNO);
  localparam int WR = $clog2(MAX_RODADAS + 1);

  localparam logic [4:0] INICIAL       = 5'd0;
  localparam logic [4:0] RESETA_TUDO   = 5'd1;
  localparam logic [4:0] PREPARA_JOGO  = 5'd2;
  localparam logic [4:0] ARMAZENA_JOGO = 5'd3;
  localparam logic [4:0] PREPARA_NOITE = 5'd4;
  localparam logic [4:0] TURNO_NOITE   = 5'd5;
  localparam logic [4:0] PROXIMO_NOITE = 5'd6;
  localparam logic [4:0] PREPARA_DIA   = 5'd7;
  localparam logic [4:0] TURNO_DIA     = 5'd8;
  localparam logic [4:0] PROXIMO_DIA   = 5'd9;
  localparam logic [4:0] APURA         = 5'd10;
  localparam logic [4:0] VERIFICA_FIM  = 5'd11;
  localparam logic [4:0] FIM           = 5'd12;

  logic [4:0]    estado;
  logic [4:0]    proximo;
  logic [WJ-1:0] jogador;
  logic [WT-1:0] timer;
  logic [WR-1:0] rodada;
  logic          vivo;
  logic          turno;
  logic          expira;
  logic          ultimo;
  logic          rodada_max;

  assign vivo       = bus.vivos[jogador];
  assign turno      = (estado == TURNO_NOITE) || (estado == TURNO_DIA);
  assign expira     = (timer == WT'(TEMPO_TURNO - 1));
  assign ultimo     = (jogador == WJ'(N_JOGADORES - 1));
  assign rodada_max = (rodada == WR'(MAX_RODADAS));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:       if (bus.jogar) proximo = RESETA_TUDO;
      RESETA_TUDO:   proximo = PREPARA_JOGO;
      PREPARA_JOGO:  if (bus.passa) proximo = ARMAZENA_JOGO;
      ARMAZENA_JOGO: proximo = PREPARA_NOITE;
      PREPARA_NOITE: proximo = TURNO_NOITE;
      TURNO_NOITE:   if (!vivo || bus.passa || expira) proximo = PROXIMO_NOITE;
      PROXIMO_NOITE: proximo = ultimo ? PREPARA_DIA : TURNO_NOITE;
      PREPARA_DIA:   proximo = TURNO_DIA;
      TURNO_DIA:     if (!vivo || bus.passa || expira) proximo = PROXIMO_DIA;
      PROXIMO_DIA:   proximo = ultimo ? APURA : TURNO_DIA;
      APURA:         proximo = VERIFICA_FIM;
      VERIFICA_FIM:  proximo = (bus.fim_jogo || rodada_max) ? FIM : PREPARA_NOITE;
      FIM:           if (bus.jogar) proximo = RESETA_TUDO;
      default:       proximo = INICIAL;
    endcase
  end

  // Player index, turn timer and round counter; updates apply on the edge leaving each state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jogador <= '0;
      timer   <= '0;
      rodada  <= '0;
    end else begin
      case (estado)
        RESETA_TUDO: begin
          jogador <= '0;
          timer   <= '0;
          rodada  <= '0;
        end
        PREPARA_NOITE: begin
          if (!rodada_max) rodada <= rodada + 1'b1;
          jogador <= '0;
          timer   <= '0;
        end
        PREPARA_DIA: begin
          jogador <= '0;
          timer   <= '0;
        end
        TURNO_NOITE, TURNO_DIA: begin
          if (vivo && !bus.passa && !expira) timer <= timer + 1'b1;
        end
        PROXIMO_NOITE, PROXIMO_DIA: begin
          if (!ultimo) begin
            jogador <= jogador + 1'b1;
            timer   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rst_global    = 1'b0;
    bus.zera_CS       = 1'b0;
    bus.e_seed_reg    = 1'b0;
    bus.e_acao_noite  = 1'b0;
    bus.e_voto        = 1'b0;
    bus.e_apura       = 1'b0;
    bus.noite         = 1'b0;
    bus.pronto        = 1'b0;
    bus.timeout       = turno && vivo && expira && !bus.passa;
    bus.jogador_atual = jogador;
    bus.rodada        = rodada;
    bus.db_estado     = (estado <= FIM) ? estado : 5'b11111;
    case (estado)
      INICIAL, RESETA_TUDO: begin
        bus.rst_global = 1'b1;
        bus.zera_CS    = 1'b1;
      end
      ARMAZENA_JOGO: bus.e_seed_reg = 1'b1;
      PREPARA_NOITE, PROXIMO_NOITE: bus.noite = 1'b1;
      TURNO_NOITE: begin
        bus.noite        = 1'b1;
        bus.e_acao_noite = vivo;
      end
      TURNO_DIA:   bus.e_voto  = vivo;
      APURA:       bus.e_apura = 1'b1;
      FIM:         bus.pronto  = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uc_partida.sv
// Bench for uc_partida: a match-level trace generator drives random turns and queues the
// expected per-cycle outputs; a negedge monitor pops and compares them against the DUT.
module tb_uc_partida;
  localparam int N  = 4;
  localparam int T  = 8;
  localparam int M  = 2;
  localparam int WJ = $clog2(N);
  localparam int WR = $clog2(M + 1);

  localparam logic [4:0] S_INI = 5'd0,  S_RES = 5'd1,  S_PJ  = 5'd2,  S_ARM = 5'd3;
  localparam logic [4:0] S_PN  = 5'd4,  S_TN  = 5'd5,  S_XN  = 5'd6,  S_PD  = 5'd7;
  localparam logic [4:0] S_TD  = 5'd8,  S_XD  = 5'd9,  S_AP  = 5'd10, S_VF  = 5'd11;
  localparam logic [4:0] S_FIM = 5'd12;

  typedef struct packed {
    logic          rst_global;
    logic          zera_cs;
    logic          e_seed;
    logic          e_acao;
    logic          e_voto;
    logic          e_apura;
    logic          timeout;
    logic          noite;
    logic          pronto;
    logic [WJ-1:0] jog;
    logic [WR-1:0] rod;
    logic [4:0]    db;
  } outs_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uc_partida_if #(.N_JOGADORES(N), .MAX_RODADAS(M)) bus ();
  uc_partida #(.N_JOGADORES(N), .TEMPO_TURNO(T), .MAX_RODADAS(M)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  outs_t        exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  int           jog_m  = 0;
  int           rod_m  = 0;
  logic [N-1:0] vivos_r = '1;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t expect_of(input logic [4:0] st, input int jog, input int rod,
                                      input logic alive, input logic ps, input logic last_tick);
    outs_t o;
    o.rst_global = (st == S_INI) || (st == S_RES);
    o.zera_cs    = (st == S_INI) || (st == S_RES);
    o.e_seed     = (st == S_ARM);
    o.e_acao     = (st == S_TN) && alive;
    o.e_voto     = (st == S_TD) && alive;
    o.e_apura    = (st == S_AP);
    o.timeout    = ((st == S_TN) || (st == S_TD)) && alive && last_tick && !ps;
    o.noite      = (st == S_PN) || (st == S_TN) || (st == S_XN);
    o.pronto     = (st == S_FIM);
    o.jog        = jog[WJ-1:0];
    o.rod        = rod[WR-1:0];
    o.db         = st;
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  // Drive one cycle's inputs and queue what the DUT must show during that cycle.
  task automatic step(input logic [4:0] st, input logic jg, input logic ps, input logic fj,
                      input logic last_tick);
    logic alive;
    alive        = vivos_r[jog_m[WJ-1:0]];
    bus.jogar    = jg;
    bus.passa    = ps;
    bus.fim_jogo = fj;
    bus.vivos    = vivos_r;
    exp_q.push_back(expect_of(st, jog_m, rod_m, alive, ps, last_tick));
    @(posedge clock);
    #1;
  endtask

  task automatic phase(input bit night);
    logic [4:0] sp, stn, sx;
    int d;
    sp  = night ? S_PN : S_PD;
    stn = night ? S_TN : S_TD;
    sx  = night ? S_XN : S_XD;
    step(sp, rb(), rb(), rb(), 1'b0);
    if (night && rod_m < M) rod_m++;
    for (int p = 0; p < N; p++) begin
      jog_m = p;
      if (!vivos_r[p]) begin
        step(stn, rb(), rb(), rb(), 1'b0);
      end else begin
        d = $urandom_range(0, T);
        for (int k = 0; k < T; k++) begin
          step(stn, rb(), 1'(k == d), rb(), 1'(k == T - 1));
          if (k == d) break;
        end
      end
      step(sx, rb(), rb(), rb(), 1'b0);
    end
  endtask

  task automatic start_game(input logic [4:0] from_st);
    repeat ($urandom_range(1, 3)) step(from_st, 1'b0, rb(), rb(), 1'b0);
    step(from_st, 1'b1, rb(), rb(), 1'b0);
    step(S_RES, rb(), rb(), rb(), 1'b0);
    jog_m = 0;
    rod_m = 0;
    repeat ($urandom_range(0, 3)) step(S_PJ, rb(), 1'b0, rb(), 1'b0);
    step(S_PJ, rb(), 1'b1, rb(), 1'b0);
    step(S_ARM, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic run_match(input logic [4:0] from_st, input logic [N-1:0] vv, input int fim_round);
    logic fj;
    vivos_r = vv;
    start_game(from_st);
    forever begin
      phase(1'b1);
      phase(1'b0);
      step(S_AP, rb(), rb(), rb(), 1'b0);
      fj = (fim_round != 0) && (rod_m == fim_round);
      step(S_VF, rb(), rb(), fj, 1'b0);
      if (fj || rod_m == M) break;
    end
    repeat ($urandom_range(1, 3)) step(S_FIM, 1'b0, rb(), rb(), 1'b0);
  endtask

  always @(negedge clock) begin
    outs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.rst_global, bus.zera_CS, bus.e_seed_reg, bus.e_acao_noite, bus.e_voto,
           bus.e_apura, bus.timeout, bus.noite, bus.pronto, bus.jogador_atual,
           bus.rodada, bus.db_estado};
      cyc++;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: actual db=%0d jog=%0d rod=%0d ctl=%b, required db=%0d jog=%0d rod=%0d ctl=%b",
                 cyc, a.db, a.jog, a.rod, a[17:9], e.db, e.jog, e.rod, e[17:9]);
      end
    end
  end

  initial begin
    bus.jogar    = 1'b0;
    bus.passa    = 1'b0;
    bus.fim_jogo = 1'b0;
    bus.vivos    = '1;
    @(posedge clock);
    #1;
    repeat (3) step(S_INI, rb(), rb(), rb(), 1'b0);
    reset = 1'b1;

    run_match(S_INI, 4'b1111, 0);
    run_match(S_FIM, 4'b0101, 1);
    run_match(S_FIM, N'($urandom), $urandom_range(0, 2));
    run_match(S_FIM, 4'b0000, 1);
    run_match(S_FIM, N'($urandom), $urandom_range(0, 2));

    // Abort a match in the middle of a day turn with an off-edge reset.
    vivos_r = 4'b1111;
    start_game(S_FIM);
    phase(1'b1);
    step(S_PD, rb(), rb(), rb(), 1'b0);
    jog_m        = 0;
    bus.jogar    = 1'b0;
    bus.passa    = 1'b0;
    bus.fim_jogo = 1'b0;
    bus.vivos    = vivos_r;
    exp_q.push_back(expect_of(S_TD, jog_m, rod_m, 1'b1, 1'b0, 1'b0));
    #6;
    reset = 1'b0;
    #1;
    chk("async_reset db_estado", int'(bus.db_estado), 0);
    chk("async_reset jogador_atual", int'(bus.jogador_atual), 0);
    chk("async_reset rodada", int'(bus.rodada), 0);
    chk("async_reset rst_global", int'(bus.rst_global), 1);
    jog_m = 0;
    rod_m = 0;
    @(posedge clock);
    #1;
    repeat (2) step(S_INI, rb(), rb(), rb(), 1'b0);
    reset = 1'b1;
    run_match(S_INI, 4'b1111, 1);

    repeat (3) @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: actual %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
